riscv_fstage_prefetch: RTL and testbench
========================================

// Module: riscv_fstage_prefetch
// PURPOSE
//  RV64 fetch stage; sits directly upstream of the decode stage (riscv_dstage).
//  - Owns the fetch PC and issues in-order requests to instruction memory.
//  - Buffers returned instructions with their PC in a FQ_DEPTH-entry fetch queue.
//  - Presents the queue head to decode as {valid, instr, pc, pcplus4}.
//  - Honours decode stall and execute-stage branch/jump redirects.
// PARAMETERS
//  XLEN      64   PC / address width
//  RESET_PC  0    fetch PC loaded on reset
//  FQ_DEPTH  2    fetch-queue entries = max requests in flight; power of 2, >=2
// PORTS
//  i_riscv_clk                 in   1     clock, rising edge
//  i_riscv_rst                 in   1     asynchronous active-high reset
//  i_riscv_fstage_stall        in   1     decode cannot accept this cycle
//  i_riscv_fstage_redirect     in   1     branch taken / jump: flush and refetch
//  i_riscv_fstage_redirect_pc  in   XLEN  redirect target
//  o_riscv_fstage_imem_req     out  1     request valid
//  o_riscv_fstage_imem_addr    out  XLEN  request address (word aligned)
//  i_riscv_fstage_imem_gnt     in   1     request accepted this cycle
//  i_riscv_fstage_imem_rvalid  in   1     response valid (in order, >=1 cycle after gnt)
//  i_riscv_fstage_imem_rdata   in   32    response instruction
//  o_riscv_fstage_valid        out  1     instr/pc valid to decode
//  o_riscv_fstage_instr        out  32    instruction
//  o_riscv_fstage_pc           out  XLEN  PC of instr
//  o_riscv_fstage_pcplus4      out  XLEN  pc + 4, modulo 2^XLEN
// BEHAVIOUR
//  - Reset (async): npc=RESET_PC; queue, alloc count, drop count cleared.
//    All outputs 0, except imem_addr=RESET_PC.
//  - Issue:
//    - req = !redirect && (alloc < FQ_DEPTH); addr = npc.
//    - On req&&gnt: allocate tail entry, store pc=npc, mark not-filled; npc += 4.
//    - While req && !gnt, addr holds stable.
//  - Fill: rvalid with drop_cnt==0 writes rdata into oldest not-filled entry.
//    - rvalid with no outstanding request is illegal (assertion).
//  - Output: valid = head filled && !redirect; instr/pc from head; pcplus4 = pc+4.
//    - Consume = valid && !stall: pop head.
//    - While stalled, outputs stay stable.
//    - Pop and allocate may happen in the same cycle; count unchanged.
//  - Redirect (priority over stall, issue, pop):
//    - All entries discarded; npc <= {redirect_pc[XLEN-1:2],2'b00}.
//    - drop_cnt <= drop_cnt + (issued-not-returned) - rvalid.
//    - Next cycle issue resumes from the new npc.
//    - Later rvalid with drop_cnt>0: discarded, drop_cnt--.
//    - New requests may issue while drop_cnt>0.
//    - drop_cnt width clog2(FQ_DEPTH)+1.
//  - Latency: gnt at cycle N, rvalid at N+k -> valid at N+k+1 (registered fill); no bypass.
//  - Full: alloc==FQ_DEPTH -> req low until a pop or redirect.
//  - Empty: valid=0; outputs hold last values.
//  - npc wraps modulo 2^XLEN.
//  - Reset mid-operation clears all state immediately; imem is reset with the core.
// TESTING
//  1. Reset release; gnt=1, rvalid one cycle after gnt; rdata 0x00a00413, 0x01400493, 0x00100317
//     -> imem_addr 0x0,0x4,0x8 on consecutive cycles.
//     -> o_valid with pc 0x0/0x4/0x8, pcplus4 0x4/0x8/0xC, matching instr, first valid 2 cycles after first gnt.
//  2. Stall held 4 cycles, FQ_DEPTH=2
//     -> req drops after 2 allocations; instr/pc frozen.
//     -> on release, pcs continue 0x8, 0xC with no gap or duplicate.
//  3. Redirect to 0x100008 with 2 requests outstanding
//     -> both responses dropped; next o_valid pc=0x100008, no stale instr.
//  4. Redirect + rvalid + stall in one cycle
//     -> redirect wins, drop_cnt excludes that response.
//     -> redirect_pc 0x2A -> fetch addr 0x28.
//  5. gnt low 4 cycles -> req and addr 0x10 held; single entry allocated on gnt.
//  6. Async reset mid-stream with 2 outstanding -> outputs 0 immediately, next fetch addr RESET_PC.

Source files
------------

// File: rtl/riscv_fstage_prefetch_if.sv
// Fetch-stage bundle: decode-side control, instruction-memory port and the decode-facing output.
// "master" is the fetch stage; "slave" is its environment (memory plus decode/execute).
interface riscv_fstage_prefetch_if #(
    parameter int XLEN = 64
);
    logic            stall;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;
    logic            valid;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcplus4;

    modport master (
        input  stall, redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata,
        output imem_req, imem_addr, valid, instr, pc, pcplus4
    );

    modport slave (
        output stall, redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata,
        input  imem_req, imem_addr, valid, instr, pc, pcplus4
    );
endinterface

// File: rtl/riscv_fstage_prefetch.sv
// RV64 fetch stage: owns the fetch PC, issues in-order imem requests and buffers responses
// in a small fetch queue whose head is presented to decode.
module riscv_fstage_prefetch #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
    parameter int              FQ_DEPTH = 2
) (
    input  logic                    i_riscv_clk,
    input  logic                    i_riscv_rst,
    riscv_fstage_prefetch_if.master fs
);
    localparam int              PW      = $clog2(FQ_DEPTH);
    localparam int              CW      = PW + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(FQ_DEPTH);
    localparam logic [CW-1:0]   ONE_C   = CW'(1'b1);
    localparam logic [XLEN-1:0] FOUR_C  = XLEN'(3'd4);

    // Pointers carry one wrap bit: alloc = tail-head, outstanding = tail-fill, filled = fill-head.
    logic [XLEN-1:0] npc_r;
    logic [CW-1:0]   head_r, tail_r, fill_r, drop_r;
    logic [XLEN-1:0] pc_q_r    [FQ_DEPTH];
    logic [31:0]     instr_q_r [FQ_DEPTH];
    logic [31:0]     hold_instr_r;
    logic [XLEN-1:0] hold_pc_r, hold_pcplus4_r;

    logic [CW-1:0]   alloc_s, outstanding_s;
    logic            req_s, issue_s, fill_s, pop_s, head_filled_s;
    logic [PW-1:0]   head_idx_s, tail_idx_s, fill_idx_s;

    // Queue occupancy and handshake decode
    always_comb begin
        alloc_s       = tail_r - head_r;
        outstanding_s = tail_r - fill_r;
        head_filled_s = (fill_r != head_r);
        head_idx_s    = head_r[PW-1:0];
        tail_idx_s    = tail_r[PW-1:0];
        fill_idx_s    = fill_r[PW-1:0];
        req_s         = !i_riscv_rst && !fs.redirect && (alloc_s < DEPTH_C);
        issue_s       = req_s && fs.imem_gnt;
        fill_s        = fs.imem_rvalid && (drop_r == {CW{1'b0}}) && (outstanding_s != {CW{1'b0}});
        pop_s         = head_filled_s && !fs.redirect && !fs.stall;
    end

    // Decode-facing outputs: live head entry when filled, otherwise the last values shown
    always_comb begin
        fs.imem_req  = req_s;
        fs.imem_addr = npc_r;
        fs.valid     = head_filled_s && !fs.redirect;
        if (head_filled_s) begin
            fs.instr   = instr_q_r[head_idx_s];
            fs.pc      = pc_q_r[head_idx_s];
            fs.pcplus4 = pc_q_r[head_idx_s] + FOUR_C;
        end else begin
            fs.instr   = hold_instr_r;
            fs.pc      = hold_pc_r;
            fs.pcplus4 = hold_pcplus4_r;
        end
    end

    // Fetch PC, queue pointers and the count of responses still owed to a flushed stream
    always_ff @(posedge i_riscv_clk or posedge i_riscv_rst) begin
        if (i_riscv_rst) begin
            npc_r  <= RESET_PC;
            head_r <= {CW{1'b0}};
            tail_r <= {CW{1'b0}};
            fill_r <= {CW{1'b0}};
            drop_r <= {CW{1'b0}};
        end else if (fs.redirect) begin
            npc_r  <= {fs.redirect_pc[XLEN-1:2], 2'b00};
            head_r <= {CW{1'b0}};
            tail_r <= {CW{1'b0}};
            fill_r <= {CW{1'b0}};
            // A response arriving now is either already owed or is one of the outstanding ones
            drop_r <= drop_r + outstanding_s - {{(CW-1){1'b0}}, fs.imem_rvalid};
        end else begin
            if (issue_s) begin
                npc_r  <= npc_r + FOUR_C;
                tail_r <= tail_r + ONE_C;
            end
            if (fill_s) begin
                fill_r <= fill_r + ONE_C;
            end
            if (pop_s) begin
                head_r <= head_r + ONE_C;
            end
            if (fs.imem_rvalid && (drop_r != {CW{1'b0}})) begin
                drop_r <= drop_r - ONE_C;
            end
        end
    end

    // Queue payload storage; validity is tracked purely by the pointers
    always_ff @(posedge i_riscv_clk) begin
        if (issue_s) begin
            pc_q_r[tail_idx_s] <= npc_r;
        end
        if (fill_s) begin
            instr_q_r[fill_idx_s] <= fs.imem_rdata;
        end
    end

    // Shadow of the most recent head entry so an empty queue keeps showing it
    always_ff @(posedge i_riscv_clk or posedge i_riscv_rst) begin
        if (i_riscv_rst) begin
            hold_instr_r   <= 32'h0000_0000;
            hold_pc_r      <= {XLEN{1'b0}};
            hold_pcplus4_r <= {XLEN{1'b0}};
        end else if (head_filled_s) begin
            hold_instr_r   <= instr_q_r[head_idx_s];
            hold_pc_r      <= pc_q_r[head_idx_s];
            hold_pcplus4_r <= pc_q_r[head_idx_s] + FOUR_C;
        end
    end

    riscv_fstage_prefetch_chk #(.CW(CW)) u_chk (
        .clk         (i_riscv_clk),
        .rst         (i_riscv_rst),
        .rvalid      (fs.imem_rvalid),
        .drop_cnt    (drop_r),
        .outstanding (outstanding_s),
        .alloc       (alloc_s),
        .depth       (DEPTH_C)
    );
endmodule

// Protocol checker for the fetch stage's memory interface and queue bookkeeping.
module riscv_fstage_prefetch_chk #(
    parameter int CW = 2
) (
    input logic          clk,
    input logic          rst,
    input logic          rvalid,
    input logic [CW-1:0] drop_cnt,
    input logic [CW-1:0] outstanding,
    input logic [CW-1:0] alloc,
    input logic [CW-1:0] depth
);
    a_rvalid_requested: assert property (@(posedge clk) disable iff (rst)
        rvalid |-> ((drop_cnt != {CW{1'b0}}) || (outstanding != {CW{1'b0}})));
    a_alloc_bounded: assert property (@(posedge clk) disable iff (rst) alloc <= depth);
endmodule

// File: tb/tb_riscv_fstage_prefetch.sv
// Randomised scoreboard bench for riscv_fstage_prefetch: an in-order memory model with random
// latency, plus a stream-level model of which PCs decode must see and when.
module tb_riscv_fstage_prefetch;
    localparam int          XLEN = 64;
    localparam int          D    = 2;
    localparam logic [63:0] RPC  = 64'h0;

    typedef struct { logic [63:0] pc; logic [31:0] instr; int ret; } exp_t;
    typedef struct { logic [63:0] addr; int due; bit stale; } mem_t;

    logic i_riscv_clk = 1'b0;
    logic i_riscv_rst = 1'b1;
    riscv_fstage_prefetch_if #(.XLEN(XLEN)) fs_bus ();

    riscv_fstage_prefetch #(.XLEN(XLEN), .RESET_PC(RPC), .FQ_DEPTH(D)) dut (
        .i_riscv_clk (i_riscv_clk),
        .i_riscv_rst (i_riscv_rst),
        .fs          (fs_bus)
    );

    always #5 i_riscv_clk = ~i_riscv_clk;

    exp_t        exp_q[$];
    mem_t        mem_q[$];
    logic [63:0] model_pc = RPC;
    int          iter = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_consumed = 0;
    int          first_gnt = -1;
    int          first_valid = -1;
    bit          in_reset = 1'b1;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        logic [31:0] h;
        case (a)
            64'h0:   h = 32'h00a0_0413;
            64'h4:   h = 32'h0140_0493;
            64'h8:   h = 32'h0010_0317;
            default: h = a[31:0] ^ a[63:32] ^ 32'h9e37_79b9;
        endcase
        return h;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (iter %0d)", name, act, req, iter);
        end
    endtask

    // Asynchronous reset away from any clock edge; outputs must clear at once
    task automatic do_reset();
        in_reset = 1'b1;
        @(negedge i_riscv_clk);
        #3;
        i_riscv_rst = 1'b1;
        fs_bus.stall = 1'b0; fs_bus.redirect = 1'b0; fs_bus.redirect_pc = 64'h0;
        fs_bus.imem_gnt = 1'b0; fs_bus.imem_rvalid = 1'b0; fs_bus.imem_rdata = 32'h0;
        #1;
        chk("rst_req", {63'h0, fs_bus.imem_req}, 64'h0);
        chk("rst_addr", fs_bus.imem_addr, RPC);
        chk("rst_valid", {63'h0, fs_bus.valid}, 64'h0);
        chk("rst_instr", {32'h0, fs_bus.instr}, 64'h0);
        chk("rst_pc", fs_bus.pc, 64'h0);
        chk("rst_pcplus4", fs_bus.pcplus4, 64'h0);
        exp_q.delete();
        mem_q.delete();
        model_pc    = RPC;
        first_gnt   = -1;
        first_valid = -1;
        repeat (2) @(negedge i_riscv_clk);
        i_riscv_rst = 1'b0;
        in_reset    = 1'b0;
    endtask

    // One cycle of stimulus: drive at the falling edge, then predict what the next rising edge does
    task automatic step(input bit st, input bit rd, input logic [63:0] rpc, input bit gnt_en,
                        input int lat_max);
        mem_t m;
        bit   marked;
        @(negedge i_riscv_clk);
        iter++;
        fs_bus.stall       = st;
        fs_bus.redirect    = rd;
        fs_bus.redirect_pc = rpc;
        fs_bus.imem_gnt    = gnt_en && (mem_q.size() < D);
        if (mem_q.size() > 0 && mem_q[0].due <= iter) begin
            fs_bus.imem_rvalid = 1'b1;
            fs_bus.imem_rdata  = instr_of(mem_q[0].addr);
        end else begin
            fs_bus.imem_rvalid = 1'b0;
            fs_bus.imem_rdata  = $urandom();
        end
        #1;
        chk("req", {63'h0, fs_bus.imem_req}, {63'h0, (!rd && exp_q.size() < D)});
        if (fs_bus.imem_req) chk("addr", fs_bus.imem_addr, model_pc);
        if (fs_bus.imem_rvalid) begin
            m = mem_q.pop_front();
            marked = 1'b0;
            if (!m.stale && !rd) begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    if (!marked && exp_q[i].ret < 0) begin
                        exp_q[i].ret = iter;
                        marked = 1'b1;
                    end
                end
            end
        end
        if (fs_bus.imem_req && fs_bus.imem_gnt) begin
            exp_q.push_back('{pc: model_pc, instr: instr_of(model_pc), ret: -1});
            mem_q.push_back('{addr: fs_bus.imem_addr, due: iter + 1 + $urandom_range(lat_max), stale: 1'b0});
            model_pc = model_pc + 64'd4;
            if (first_gnt < 0) first_gnt = iter;
        end
        if (rd) begin
            exp_q.delete();
            foreach (mem_q[i]) mem_q[i].stale = 1'b1;
            model_pc = {rpc[63:2], 2'b00};
        end
    endtask

    // Monitor: compares the decode-facing head against the scoreboard and pops on consume
    initial begin
        forever begin
            @(negedge i_riscv_clk);
            #2;
            if (!in_reset) begin
                chk("valid", {63'h0, fs_bus.valid},
                    {63'h0, (exp_q.size() > 0 && exp_q[0].ret >= 0 && exp_q[0].ret < iter && !fs_bus.redirect)});
                if (fs_bus.valid && exp_q.size() > 0) begin
                    chk("pc", fs_bus.pc, exp_q[0].pc);
                    chk("instr", {32'h0, fs_bus.instr}, {32'h0, exp_q[0].instr});
                    chk("pcplus4", fs_bus.pcplus4, exp_q[0].pc + 64'd4);
                    if (first_valid < 0) first_valid = iter;
                    if (!fs_bus.stall) begin
                        void'(exp_q.pop_front());
                        n_consumed++;
                    end
                end
            end
        end
    end

    initial begin
        fs_bus.stall = 1'b0; fs_bus.redirect = 1'b0; fs_bus.redirect_pc = 64'h0;
        fs_bus.imem_gnt = 1'b0; fs_bus.imem_rvalid = 1'b0; fs_bus.imem_rdata = 32'h0;
        do_reset();

        // Streaming with single-cycle memory latency
        repeat (8) step(1'b0, 1'b0, 64'h0, 1'b1, 0);
        chk("first_valid_latency", 64'(first_valid - first_gnt), 64'd2);

        // Decode stall fills the queue, then drains without gaps
        repeat (4) step(1'b1, 1'b0, 64'h0, 1'b1, 0);
        repeat (4) step(1'b0, 1'b0, 64'h0, 1'b1, 0);

        // Redirect with two slow requests in flight
        repeat (2) step(1'b0, 1'b0, 64'h0, 1'b1, 4);
        step(1'b0, 1'b1, 64'h0000_0000_0010_0008, 1'b1, 0);
        repeat (10) step(1'b0, 1'b0, 64'h0, 1'b1, 0);

        // Redirect, response and stall coincide; misaligned target
        step(1'b0, 1'b0, 64'h0, 1'b1, 0);
        step(1'b1, 1'b1, 64'h0000_0000_0000_002a, 1'b1, 0);
        repeat (6) step(1'b0, 1'b0, 64'h0, 1'b1, 1);

        // Grant withheld: request and address must hold
        repeat (4) step(1'b0, 1'b0, 64'h0, 1'b0, 0);
        repeat (4) step(1'b0, 1'b0, 64'h0, 1'b1, 0);

        // Reset with requests outstanding
        repeat (2) step(1'b0, 1'b0, 64'h0, 1'b1, 3);
        do_reset();
        repeat (4) step(1'b0, 1'b0, 64'h0, 1'b1, 0);

        // Random traffic, including redirects near the top of the address space
        for (int n = 0; n < 3000; n++) begin
            logic [63:0] t;
            t = {$urandom(), $urandom()};
            if ($urandom_range(3) == 0) t = 64'hffff_ffff_ffff_fff0 | {60'h0, t[3:0]};
            step($urandom_range(3) == 0, $urandom_range(19) == 0, t, $urandom_range(3) != 0, 3);
            if (n % 1000 == 999) do_reset();
        end
        chk("progress", {63'h0, (n_consumed > 500)}, 64'h1);

        #5;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
